// File: rtl/mem_arbiter_if.sv
// Two-port request bus plus memory command/response bus for mem_arbiter.
// slave = arbiter view, master = requesters and memory model view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic                prio_mode;
  logic [1:0]          req;
  logic [1:0]          we;
  logic [AW-1:0]       addr0;
  logic [AW-1:0]       addr1;
  logic [DW-1:0]       wdata0;
  logic [DW-1:0]       wdata1;
  logic [DW/8-1:0]     be0;
  logic [DW/8-1:0]     be1;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DW-1:0]       rdata;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW/8-1:0]     mem_be;
  logic [DW-1:0]       mem_rdata;
  logic                busy;

  modport slave (
    input  prio_mode, req, we, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output prio_mode, req, we, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single synchronous-read memory.
// Round-robin or fixed-priority selection; request fields pass through unlatched.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   sel;
  logic   lp;
  logic   win;
  logic   issue;

  // Tie in round-robin goes to the port not served last.
  always_comb begin
    win = 1'b0;
    if (bus.prio_mode)
      win = ~bus.req[0];
    else if (bus.req == 2'b11)
      win = ~lp;
    else
      win = bus.req[1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      lp    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            sel   <= win;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (bus.req[sel]) begin
            lp    <= sel;
            state <= bus.we[sel] ? ST_IDLE : ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by RST so an access caught by reset is dropped that cycle.
  assign issue = ~RST && (state == ST_GRANT) && bus.req[sel];

  always_comb begin
    bus.gnt       = 2'b00;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (issue) begin
      bus.gnt       = sel ? 2'b10 : 2'b01;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.we[sel];
      bus.mem_addr  = sel ? bus.addr1  : bus.addr0;
      bus.mem_wdata = sel ? bus.wdata1 : bus.wdata0;
      bus.mem_be    = sel ? bus.be1    : bus.be0;
    end
  end

  always_comb begin
    bus.rvalid = 2'b00;
    bus.rdata  = '0;
    if (~RST && state == ST_WAIT) begin
      bus.rvalid = sel ? 2'b10 : 2'b01;
      bus.rdata  = bus.mem_rdata;
    end
  end

  assign bus.busy = ~RST && (state == ST_GRANT || state == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a timestamp-level model predicts each grant
// and read return; a separate monitor compares every cycle against it.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic          prio;
  logic [1:0]    req_d;
  logic [1:0]    we_d;
  logic [AW-1:0] addr_d  [2];
  logic [DW-1:0] wdata_d [2];
  logic [BW-1:0] be_d    [2];

  assign bus.prio_mode = prio;
  assign bus.req       = req_d;
  assign bus.we        = we_d;
  assign bus.addr0     = addr_d[0];
  assign bus.addr1     = addr_d[1];
  assign bus.wdata0    = wdata_d[0];
  assign bus.wdata1    = wdata_d[1];
  assign bus.be0       = be_d[0];
  assign bus.be1       = be_d[1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 ^ (i * 32'h01010101));
  endfunction

  // Environment memory: 16 words indexed by addr[5:2], one-cycle read latency.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mem_rdata_q;
  bit            mem_init = 1'b0;
  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < BW; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        mem_rdata_q <= mem[bus.mem_addr[5:2]];
      end
    end
  end

  typedef struct {
    int            cyc;
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    bit            dead;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  bit   exp_busy;
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(string n, logic [71:0] g, logic [71:0] x);
    ncmp++;
    if (g !== x) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h required=%h", n, cyc, g, x);
    end
  endtask

  // Reference model: an access decided in an idle cycle k issues at k+1;
  // the arbiter is free again at k+2 (write/withdraw) or k+3 (read).
  initial begin : model
    logic [DW-1:0] refmem [16];
    int   k, pw, free_at, idx;
    bit   pend, lastp;
    exp_t e;
    for (int i = 0; i < 16; i++) refmem[i] = init_val(i);
    lastp = 1'b1; pend = 1'b0; free_at = 0; pw = 0;
    forever begin
      @(negedge CLK);
      k = cyc;
      exp_busy = !RST && (pend || (rq.size() > 0 && rq[$].cyc == k && !rq[$].dead));
      if (RST) begin
        lastp = 1'b1; pend = 1'b0; free_at = k + 1;
        foreach (rq[i]) if (rq[i].cyc >= k) rq[i].dead = 1'b1;
      end else if (pend) begin
        pend = 1'b0;
        if (req_d[pw]) begin
          e.cyc = k; e.port = pw; e.we = we_d[pw]; e.addr = addr_d[pw];
          e.data = wdata_d[pw]; e.be = be_d[pw]; e.dead = 1'b0;
          gq.push_back(e);
          lastp = (pw == 1);
          idx = int'(addr_d[pw][5:2]);
          if (e.we) begin
            for (int b = 0; b < BW; b++)
              if (e.be[b]) refmem[idx][8*b +: 8] = e.data[8*b +: 8];
            free_at = k + 1;
          end else begin
            e.cyc = k + 1; e.data = refmem[idx];
            rq.push_back(e);
            free_at = k + 2;
          end
        end else begin
          free_at = k + 1;
        end
      end else if (k >= free_at && req_d != 2'b00) begin
        if (prio)                 pw = req_d[0] ? 0 : 1;
        else if (req_d == 2'b11)  pw = lastp ? 0 : 1;
        else                      pw = req_d[1] ? 1 : 0;
        pend = 1'b1;
      end
    end
  end

  int gi = 0;
  int ri = 0;

  initial begin : monitor
    int k;
    logic [71:0] g, x;
    forever begin
      @(negedge CLK);
      #1;
      k = cyc;
      g = 72'({bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be});
      if (gi < gq.size() && gq[gi].cyc == k) begin
        x = 72'({(gq[gi].port == 1) ? 2'b10 : 2'b01, 1'b1, gq[gi].we,
                 gq[gi].addr, gq[gi].data, gq[gi].be});
        gi++;
        chk("grant", g, x);
      end else begin
        chk("no_grant", g, 72'd0);
      end
      while (ri < rq.size() && rq[ri].dead) ri++;
      g = 72'({bus.rvalid, bus.rdata});
      if (ri < rq.size() && rq[ri].cyc == k) begin
        x = 72'({(rq[ri].port == 1) ? 2'b10 : 2'b01, rq[ri].data});
        ri++;
        chk("rvalid", g, x);
      end else begin
        chk("no_rvalid", g, 72'd0);
      end
      chk("busy", 72'(bus.busy), 72'(exp_busy));
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Holds the request until its gnt (or for one cycle when pulse is set).
  task automatic issue(int p, bit w, logic [AW-1:0] a, logic [DW-1:0] d,
                       logic [BW-1:0] b, bit pulse);
    bit got;
    we_d[p] = w; addr_d[p] = a; wdata_d[p] = d; be_d[p] = b; req_d[p] = 1'b1;
    if (pulse) begin
      step(1);
      req_d[p] = 1'b0;
    end else begin
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge CLK);
        if (bus.gnt[p]) got = 1'b1;
      end
      if (!got) begin
        ncmp++; nerr++;
        $display("FAIL gnt_timeout port=%0d got=none required=grant", p);
      end
      step(1);
      req_d[p] = 1'b0;
    end
  endtask

  task automatic agent(int p, int n);
    for (int t = 0; t < n; t++) begin
      step($urandom_range(1, 6));
      issue(p, 1'(($urandom & 1)), $urandom, $urandom, 4'($urandom),
            ($urandom_range(0, 7) == 0));
    end
  endtask

  bit done = 1'b0;

  initial begin : main
    int live;
    prio = 1'b0; req_d = 2'b00; we_d = 2'b00;
    for (int p = 0; p < 2; p++) begin addr_d[p] = '0; wdata_d[p] = '0; be_d[p] = '0; end
    RST = 1'b1;
    step(3);
    RST = 1'b0;

    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    step(2);
    issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    step(1);
    issue(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    step(2);

    // Round-robin, both ports reading back-to-back.
    fork
      repeat (4) issue(0, 1'b0, 32'h04, 32'h0, 4'hF, 1'b0);
      repeat (4) issue(1, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0);
    join
    step(2);

    // Fixed priority: port 1 only after port 0 stops.
    prio = 1'b1;
    fork
      repeat (3) issue(0, 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0);
      issue(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'h5, 1'b0);
    join
    step(2);
    prio = 1'b0;

    // Withdrawn request, then a tie.
    issue(0, 1'b0, 32'h18, 32'h0, 4'hF, 1'b1);
    step(2);
    fork
      issue(0, 1'b0, 32'h18, 32'h0, 4'hF, 1'b0);
      issue(1, 1'b0, 32'h1C, 32'h0, 4'hF, 1'b0);
    join
    step(2);

    // Reset landing in the read-wait cycle, then a tie.
    fork
      issue(1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
      begin step(2); RST = 1'b1; step(1); RST = 1'b0; end
    join
    step(2);
    fork
      issue(0, 1'b0, 32'h28, 32'h0, 4'hF, 1'b0);
      issue(1, 1'b0, 32'h2C, 32'h0, 4'hF, 1'b0);
    join
    step(2);

    fork
      begin
        fork
          agent(0, 40);
          agent(1, 40);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          step($urandom_range(5, 20));
          prio = 1'($urandom & 1);
          if ($urandom_range(0, 3) == 0) begin
            RST = 1'b1; step($urandom_range(1, 2)); RST = 1'b0;
          end
        end
      end
    join
    step(10);

    live = 0;
    for (int i = ri; i < rq.size(); i++) if (!rq[i].dead) live++;
    chk("grant_queue_drained", 72'(gq.size() - gi), 72'd0);
    chk("rvalid_queue_drained", 72'(live), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
